// File: rtl/regfile_pkg.sv
// Shared constants and the byte-merge helper for the multi-port register file.
package regfile_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int ZERO_ADDR  = 0;

    // Merge operates on a fixed wide word; callers zero-extend and truncate.
    localparam int MERGE_W = 256;
    localparam int MERGE_B = MERGE_W / 8;

    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0] old_v,
        input logic [MERGE_W-1:0] new_v,
        input logic [MERGE_B-1:0] be
    );
        logic [MERGE_W-1:0] r;
        for (int b = 0; b < MERGE_B; b++) begin
            r[b*8 +: 8] = be[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return r;
    endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for ID-stage hazard detection, with a registered busy count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  busy_set_en,
    input  logic [ADDR_W-1:0]     busy_set_addr,
    input  logic                  clr0_en,
    input  logic [ADDR_W-1:0]     clr0_addr,
    input  logic                  clr1_en,
    input  logic [ADDR_W-1:0]     clr1_addr,
    output logic [2**ADDR_W-1:0]  busy_vec,
    output logic [ADDR_W:0]       busy_cnt
);
    localparam int NREG  = 2**ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [NREG-1:0] busy_nxt;
    logic            set_ok;

    assign set_ok = busy_set_en &&
                    !(ZERO_REG != 0 && busy_set_addr == ADDR_W'(ZERO_ADDR));

    // Clear first, then set: a new issue outranks the writeback of the old one.
    always_comb begin
        busy_nxt = busy_vec;
        if (clr1_en) busy_nxt[clr1_addr] = 1'b0;
        if (clr0_en) busy_nxt[clr0_addr] = 1'b0;
        if (set_ok)  busy_nxt[busy_set_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_vec <= '0;
            busy_cnt <= '0;
        end else begin
            busy_vec <= busy_nxt;
            busy_cnt <= CNT_W'($countones(busy_nxt));
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: byte-enabled WB port, full-word late-load port,
// optional same-cycle bypass and a busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
    output logic [NUM_RD*DATA_W-1:0]  rd_data,
    output logic [NUM_RD-1:0]         rd_busy,
    input  logic                      wr0_en,
    input  logic [ADDR_W-1:0]         wr0_addr,
    input  logic [DATA_W-1:0]         wr0_data,
    input  logic [DATA_W/8-1:0]       wr0_be,
    input  logic                      wr1_en,
    input  logic [ADDR_W-1:0]         wr1_addr,
    input  logic [DATA_W-1:0]         wr1_data,
    input  logic                      busy_set_en,
    input  logic [ADDR_W-1:0]         busy_set_addr,
    output logic [ADDR_W:0]           busy_cnt
);
    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0] mem [NREG];
    logic [NREG-1:0]   busy_vec;

    // Value register a holds after this edge's writes; wr0 is younger and wins per byte.
    function automatic logic [DATA_W-1:0] post_write(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] old_v
    );
        logic [DATA_W-1:0] v;
        v = old_v;
        if (wr1_en && wr1_addr == a) v = wr1_data;
        if (wr0_en && wr0_addr == a)
            v = DATA_W'(byte_merge(MERGE_W'(v), MERGE_W'(wr0_data), MERGE_B'(wr0_be)));
        if (ZERO_REG != 0 && a == ADDR_W'(ZERO_ADDR)) v = '0;
        return v;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) mem[i] <= post_write(ADDR_W'(i), mem[i]);
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = rd_addr[p*ADDR_W +: ADDR_W];
        assign rd_data[p*DATA_W +: DATA_W] = !rst ? '0 :
                                             (BYPASS != 0) ? post_write(a, mem[a]) : mem[a];
        assign rd_busy[p] = busy_vec[a];
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk           (clk),
        .rst           (rst),
        .busy_set_en   (busy_set_en),
        .busy_set_addr (busy_set_addr),
        .clr0_en       (wr0_en),
        .clr0_addr     (wr0_addr),
        .clr1_en       (wr1_en),
        .clr1_addr     (wr1_addr),
        .busy_vec      (busy_vec),
        .busy_cnt      (busy_cnt)
    );
endmodule
